// File: rtl/csel_pkg.sv
// csel_pkg: shared constants, helpers and types for the pipelined
// carry-select adder/subtractor (csel_adder_pipe).
//   CSEL_WIDTH   default operand/sum width
//   CSEL_BLK     default carry-select block width
//   csel_nb()    block count (= pipeline depth) for a width/block pair
//   csel_stage_t per-stage register record at the default width
package csel_pkg;

    localparam int CSEL_WIDTH = 32;
    localparam int CSEL_BLK   = 8;

    function automatic int csel_nb(input int width, input int blk);
        return width / blk;
    endfunction

    // Stage k record: completed sum blocks 0..k, carry out of block k and the
    // conditioned operand blocks k+1..NB-1 still waiting to be added.
    // The top module declares a width-parametrised twin of this record.
    typedef struct packed {
        logic                  vld;
        logic [CSEL_WIDTH-1:0] sum;
        logic                  carry;
        logic [CSEL_WIDTH-1:0] a_tail;
        logic [CSEL_WIDTH-1:0] b_tail;
    } csel_stage_t;

endpackage

// File: rtl/csel_block.sv
// csel_block: combinational carry-select block adder.
// Both carry hypotheses are summed in parallel and the incoming carry picks one.
// Ports:
//   a, b      [BLK]  block operands
//   carry_in  1      carry into the block (select)
//   sum       [BLK]  selected block sum
//   carry_out 1      selected carry out of the block
module csel_block #(
    parameter int BLK = 8
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] b,
    input  logic           carry_in,
    output logic [BLK-1:0] sum,
    output logic           carry_out
);

    logic [BLK:0] s0;
    logic [BLK:0] s1;

    assign s0 = {1'b0, a} + {1'b0, b};
    assign s1 = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};

    assign sum       = carry_in ? s1[BLK-1:0] : s0[BLK-1:0];
    assign carry_out = carry_in ? s1[BLK]     : s0[BLK];

endmodule

// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe: pipelined carry-select adder/subtractor, one BLK-wide block
// per stage, NB = WIDTH/BLK stages, latency NB, one result per cycle.
// Optional macro CSEL_OVF_FLAG_EN adds the registered signed-overflow flag ovf.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = advance)
//   a, b [WIDTH]          operands
//   cin                   carry in (ignored when sub=1)
//   sub                   1: a - b
//   out_valid / out_ready result handshake
//   sum [WIDTH], cout     result, carry out (sub: 1 = no borrow)
//   ovf                   signed overflow (only with CSEL_OVF_FLAG_EN)
module csel_adder_pipe
    import csel_pkg::*;
#(
    parameter int WIDTH = CSEL_WIDTH,
    parameter int BLK   = CSEL_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSEL_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NB = csel_nb(WIDTH, BLK);

    if (WIDTH % BLK != 0) begin : g_cfg_err
        $fatal(1, "csel_adder_pipe: WIDTH (%0d) must be a multiple of BLK (%0d)", WIDTH, BLK);
    end

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic [WIDTH-1:0] a_tail;
        logic [WIDTH-1:0] b_tail;
    } stage_t;

    logic   advance;
    logic   vld_in [NB];
    stage_t stg_in [NB];
    logic   vld_q  [NB];
    stage_t stg_q  [NB];

    // The whole pipeline moves as one; a full output register that is not
    // being taken freezes every stage.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NB-1];
    assign sum       = stg_q[NB-1].sum;
    assign cout      = stg_q[NB-1].carry;

    for (genvar k = 0; k < NB; k++) begin : g_stage
        logic [BLK-1:0] blk_sum;
        logic           blk_carry;
        stage_t         nxt;
        logic           vld_p;
        stage_t         data_p;

        if (k == 0) begin : g_first
            // Subtraction as a + ~b + 1.
            assign vld_in[0]        = in_valid;
            assign stg_in[0].sum    = '0;
            assign stg_in[0].carry  = sub | cin;
            assign stg_in[0].a_tail = a;
            assign stg_in[0].b_tail = sub ? ~b : b;
        end else begin : g_chain
            assign vld_in[k] = vld_q[k-1];
            assign stg_in[k] = stg_q[k-1];
        end

        csel_block #(.BLK(BLK)) u_blk (
            .a         (stg_in[k].a_tail[k*BLK +: BLK]),
            .b         (stg_in[k].b_tail[k*BLK +: BLK]),
            .carry_in  (stg_in[k].carry),
            .sum       (blk_sum),
            .carry_out (blk_carry)
        );

        always_comb begin
            nxt                   = stg_in[k];
            nxt.sum[k*BLK +: BLK] = blk_sum;
            nxt.carry             = blk_carry;
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p <= 1'b0;
            end else if (advance) begin
                vld_p <= vld_in[k];
            end
        end

        if (k == NB - 1) begin : g_last
            // Last stage is the output register and must read zero in reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_p <= '0;
                end else if (advance) begin
                    data_p <= nxt;
                end
            end
`ifdef CSEL_OVF_FLAG_EN
            logic ovf_p;
            logic msb_cin;
            // Carry into the MSB recovered from its sum bit and operands.
            assign msb_cin = stg_in[k].a_tail[WIDTH-1] ^ stg_in[k].b_tail[WIDTH-1]
                             ^ blk_sum[BLK-1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_p <= 1'b0;
                end else if (advance) begin
                    ovf_p <= msb_cin ^ blk_carry;
                end
            end
            assign ovf = ovf_p;
`endif
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (advance) begin
                    data_p <= nxt;
                end
            end
        end

        assign vld_q[k] = vld_p;
        assign stg_q[k] = data_p;
    end

endmodule

// File: tb/tb_csel_adder_pipe.sv
module tb_csel_adder_pipe;

    localparam int W    = 32;
    localparam int NBLK = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic [W-1:0] sum;
`ifdef CSEL_OVF_FLAG_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    csel_adder_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CSEL_OVF_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    int           base = 0;
    int           stall_mode = 0;
    int           n_push = 0;
    int           n_pop = 0;
    bit           acc = 1'b0;
    bit           held = 1'b0;
    logic [W-1:0] hold_sum = '0;
    logic         hold_cout = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                   input logic tc, input logic ts);
        logic [W-1:0] be;
        logic [W:0]   r;
        exp_t         e;
        be     = ts ? ~tb_ : tb_;
        r      = {1'b0, ta} + {1'b0, be} + {{W{1'b0}}, (ts ? 1'b1 : tc)};
        e.sum  = r[W-1:0];
        e.cout = r[W];
        e.ovf  = (ta[W-1] == be[W-1]) && (r[W-1] != ta[W-1]);
        return e;
    endfunction

    // One clock cycle: inputs are already set at the falling edge; observe,
    // score, then let the rising edge happen.
    task automatic step();
        exp_t e;
        if (stall_mode == 1)
            out_ready = !((cyc - base) >= 5 && (cyc - base) <= 7);
        else if (stall_mode == 2)
            out_ready = ($urandom_range(0, 3) != 0);
        #1;
        acc = 1'b0;
        if (rst_n) begin
            if (held) begin
                check_val("hold_out_valid", 64'(out_valid), 64'd1);
                check_val("hold_sum", 64'(sum), 64'(hold_sum));
                check_val("hold_cout", 64'(cout), 64'(hold_cout));
            end
            if (out_valid && !out_ready)
                check_val("stall_in_ready", 64'(in_ready), 64'd0);
            if (!out_valid)
                check_val("free_in_ready", 64'(in_ready), 64'd1);
            if (in_valid && in_ready) begin
                sb.push_back(model(a, b, cin, sub));
                n_push++;
                acc = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    n_pop++;
                    check_val("sum", 64'(sum), 64'(e.sum));
                    check_val("cout", 64'(cout), 64'(e.cout));
`ifdef CSEL_OVF_FLAG_EN
                    check_val("ovf", 64'(ovf), 64'(e.ovf));
`endif
                end
            end
            held      = out_valid && !out_ready;
            hold_sum  = sum;
            hold_cout = cout;
        end else begin
            held = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic tc, input logic ts);
        a        = ta;
        b        = tb_;
        cin      = tc;
        sub      = ts;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (acc) break;
        end
        if (!acc) check_val("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) step();
        check_val("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ta, tb_;
        int lat;

        // Reset with operands offered: nothing may enter or appear.
        in_valid = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h0F0F_0F0F;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_sum", 64'(sum), 64'd0);
        check_val("rst_cout", 64'(cout), 64'd0);
`ifdef CSEL_OVF_FLAG_EN
        check_val("rst_ovf", 64'(ovf), 64'd0);
`endif
        in_valid = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("idle_out_valid", 64'(out_valid), 64'd0);
        end
        check_val("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic add and latency.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_val("latency", 64'(lat), 64'(NBLK));
        check_val("basic_sum_direct", 64'(sum), 64'h100);
        drain();

        // Directed corner operands, back to back.
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        issue(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        issue(32'h00FF_00FF, 32'h0001_FF01, 1'b0, 1'b0);
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
        drain();

        // Eight back-to-back operations with the consumer stalled for cycles 5-7.
        base       = cyc;
        stall_mode = 1;
        for (int i = 0; i < 8; i++) begin
            ta = $urandom();
            tb_ = $urandom();
            issue(ta, tb_, 1'(i % 2), 1'(i % 3 == 0));
        end
        drain();
        stall_mode = 0;
        out_ready  = 1'b1;

        // Random traffic with random back-pressure and input gaps.
        stall_mode = 2;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            ta = $urandom();
            tb_ = $urandom();
            if ($urandom_range(0, 4) == 0) tb_ = ~ta;
            issue(ta, tb_, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        stall_mode = 0;
        out_ready  = 1'b1;
        drain();
        check_val("pop_count", 64'(n_pop), 64'(n_push));

        // Reset with operations in flight and a result waiting at the output.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue(32'h1000 + 32'(i), 32'h0000_0011, 1'b0, 1'b0);
        check_val("preflush_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_out_valid", 64'(out_valid), 64'd0);
        check_val("async_rst_sum", 64'(sum), 64'd0);
        check_val("async_rst_cout", 64'(cout), 64'd0);
        sb.delete();
        held = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
        end

        // Pipeline still works after the flush.
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/csel_adder_pipe.md
Name: csel_adder_pipe

Overview:
- Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit carry-select adder.
- Splits operands into WIDTH/BLK blocks, one block per pipeline stage.
- Each stage computes both carry hypotheses for its block and selects with the registered carry of the previous stage.
- Sits between operand issue and writeback in the processor's ALU path; valid/ready handshake on both sides.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be a multiple of BLK.
- BLK, 8: block width in bits; one carry-select block per stage.
- NB, WIDTH/BLK: derived block count and pipeline depth; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in; ignored when sub=1.
- sub  input  1  1: compute a-b (b inverted, carry-in forced to 1).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB block; for sub, 1 means no borrow.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage valid bits cleared.
  - out_valid=0, sum=0, cout=0.
  - in_ready=1 once reset deasserts.
  - Reset mid-operation discards every in-flight operation; no partial result is emitted.
- Pipeline control:
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - Accept occurs on in_valid & in_ready.
  - When advance=0 every stage holds: registers, valid bits, sum and cout are stable.
  - out_valid stays 1 until out_ready.
  - Bubbles are carried as valid=0 and do not stall the pipeline.
- Operand conditioning at accept:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Stage k (0..NB-1), on advance:
  - Block k computed combinationally from the stage k-1 register (stage 0 uses the conditioned inputs).
  - s0 = a_k + b_k with carry-in 0, producing c0_k.
  - s1 = a_k + b_k with carry-in 1, producing c1_k.
  - Select: sum_k = carry_in_k ? s1 : s0; carry_out_k = carry_in_k ? c1_k : c0_k.
  - Stage 0 uses c0 directly (a single RCA is allowed, but keep the dual form for uniformity).
- Stage k register holds:
  - Valid bit.
  - Completed sum blocks 0..k.
  - carry_out_k.
  - Raw (conditioned) operand blocks k+1..NB-1, which form the skew.
- Output:
  - Output register = stage NB-1 register.
  - sum = completed blocks; cout = carry_out_{NB-1}.
- Latency:
  - Exactly NB cycles from accept to out_valid when unstalled (default 4).
  - Throughput is 1 result per cycle.
- Arithmetic: modulo 2^WIDTH; ordering is strictly FIFO.
- Boundary cases:
  - Simultaneous accept and output handshake in one cycle is legal and keeps full throughput.
  - NB=1 degenerates to one registered carry-select stage with latency 1.
  - A WIDTH not divisible by BLK is a configuration error; the block fires an elaboration-time fatal.

Optional Feature:
- Macro CSEL_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum with the same latency and stall behaviour.
  - ovf = signed overflow = carry into MSB XOR carry out of MSB, using the conditioned operands.
  - ovf resets to 0.
- Undefined: no ovf port and no extra logic.

Decomposition:
- Package csel_pkg:
  - Default WIDTH and BLK constants.
  - Function computing NB.
  - Typedef for the per-stage register record (valid, sum, carry, operand tail).
- Sub-module csel_block, parametrised by BLK:
  - Purely combinational dual-carry block adder with output select.
  - Inputs: a, b, carry_in. Outputs: sum, carry_out.
  - Instantiated NB times.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1 -> out_valid=0, sum=0, cout=0. Release reset, idle 10 cycles -> out_valid stays 0.
- Basic add: a=0x0000_00FF, b=0x0000_0001, cin=0 -> sum=0x0000_0100, cout=0, out_valid exactly 4 cycles after accept.
- Full carry ripple: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. With CSEL_OVF_FLAG_EN: a=0x7FFF_FFFF, b=1 -> ovf=1.
- Subtract: sub=1, a=5, b=7 -> sum=0xFFFF_FFFE, cout=0. sub=1, a=7, b=5 -> sum=2, cout=1.
- Back-to-back with stall: 8 consecutive operand pairs, out_ready=0 for cycles 5-7 -> in_ready drops, outputs hold stable, all 8 results emerge in order with no loss or duplication.
- Reset mid-flight: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately (asynchronously); no stale result after release.
